// File: rtl/mem_arb_defs.sv
// mem_arb_defs: sequencer state encoding and owner ids shared by the memory bus users
package mem_arb_defs;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-access-at-a-time round-robin sharing of a single memory port between CPU and DMA
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(MEM_LAT - 1);
  state_t state, state_n;
  logic owner, we_r, last_owner, win, any_req, rd_done;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] burst_cnt;
  // A locked DMA keeps the port on ties until it has taken MAX_BURST grants in a row
  function automatic logic arb(input logic c, input logic d, input logic lock,
                               input logic last, input logic [BW-1:0] cnt);
    return !c ? OWN_DMA : !d ? OWN_CPU :
           (lock && last == OWN_DMA && cnt < BURST_MAX) ? OWN_DMA : ~last;
  endfunction
  assign any_req = cpu_req || dma_req;
  assign win     = arb(cpu_req, dma_req, dma_lock, last_owner, burst_cnt);
  assign rd_done = state == WAIT && lat_cnt == '0;
  always_comb begin
    state_n = state == IDLE  ? (any_req ? ISSUE : IDLE) :
              state == ISSUE ? (we_r ? IDLE : WAIT) :
              (state == WAIT && !rd_done) ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      lat_cnt    <= '0;
      last_owner <= OWN_DMA;
      burst_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner      <= win;
        last_owner <= win;
        we_r       <= win ? dma_we : cpu_we;
        addr_r     <= win ? dma_addr : cpu_addr;
        wdata_r    <= win ? dma_wdata : cpu_wdata;
      end
      if (state == IDLE)
        burst_cnt <= (!dma_lock || (any_req && win == OWN_CPU)) ? '0 :
                     (any_req && burst_cnt != BURST_MAX) ? burst_cnt + 1'b1 : burst_cnt;
      if (state == ISSUE) lat_cnt <= LAT_LOAD;
      else if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
    end
  end
  assign busy       = state != IDLE;
  assign mem_en     = state == ISSUE;
  assign mem_we     = mem_en && we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign cpu_gnt    = mem_en && owner == OWN_CPU;
  assign dma_gnt    = mem_en && owner == OWN_DMA;
  assign cpu_rvalid = rd_done && owner == OWN_CPU;
  assign dma_rvalid = rd_done && owner == OWN_DMA;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
endmodule
